// File: rtl/pm_pkg.sv
// Program-memory responder shared definitions: widths, NOP opcode and FSM encoding.
package pm_pkg;

  localparam int unsigned PM_ADD_W    = 16;
  localparam int unsigned PM_OP_W     = 32;
  localparam int unsigned PM_DEPTH_LG = 10;

  localparam logic [PM_OP_W-1:0] PM_NOP = 32'h0000_0000;

  localparam logic PM_RUN  = 1'b0;
  localparam logic PM_LOAD = 1'b1;

  typedef enum logic {
    ST_RUN  = PM_RUN,
    ST_LOAD = PM_LOAD
  } pm_state_e;

endpackage

// File: rtl/pm_rspndr_if.sv
// Fetch bus (sequencer side) and boot-load bus (host side) of the program-memory responder.
interface pm_rspndr_if #(
  parameter int unsigned ADD_W = pm_pkg::PM_ADD_W,
  parameter int unsigned OP_W  = pm_pkg::PM_OP_W
);

  logic             ps_pm_cslt;
  logic             ps_pm_wrb;
  logic [ADD_W-1:0] ps_pm_add;
  logic [OP_W-1:0]  pm_ps_op;

  logic             ld_start;
  logic [ADD_W-1:0] ld_base;
  logic [ADD_W-1:0] ld_len;
  logic             ld_vld;
  logic [OP_W-1:0]  ld_dt;
  logic             ld_rdy;
  logic             ld_done;
  logic             pm_busy;
  logic             pm_err;

  modport master (
    output ps_pm_cslt, ps_pm_wrb, ps_pm_add,
    output ld_start, ld_base, ld_len, ld_vld, ld_dt,
    input  pm_ps_op, ld_rdy, ld_done, pm_busy, pm_err
  );

  modport slave (
    input  ps_pm_cslt, ps_pm_wrb, ps_pm_add,
    input  ld_start, ld_base, ld_len, ld_vld, ld_dt,
    output pm_ps_op, ld_rdy, ld_done, pm_busy, pm_err
  );

endinterface

// File: rtl/pm_sram.sv
// Single-port synchronous RAM, one-cycle registered read; contents are never reset.
module pm_sram #(
  parameter int unsigned AW = 10,
  parameter int unsigned DW = 32
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] addr,
  input  logic [DW-1:0] wdata,
  output logic [DW-1:0] rdata
);

  localparam int unsigned WORDS = 1 << AW;

  logic [DW-1:0] mem [WORDS];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[addr] <= wdata;
    end
    rdata <= mem[addr];
  end

endmodule

// File: rtl/pm_rspndr.sv
// Program-memory responder: serves sequencer fetches from the PM array and fills it from the host loader.
module pm_rspndr import pm_pkg::*; #(
  parameter int unsigned ADD_W    = PM_ADD_W,
  parameter int unsigned OP_W     = PM_OP_W,
  parameter int unsigned DEPTH_LG = PM_DEPTH_LG
) (
  input  logic         clk,
  input  logic         rst,
  pm_rspndr_if.slave   bus
);

  pm_state_e             state, state_nxt;
  logic [ADD_W-1:0]      ptr, ptr_nxt;
  logic [ADD_W-1:0]      cnt, cnt_nxt;
  logic                  rd_ok, rd_ok_nxt;
  logic                  done_q, done_nxt;
  logic                  err_q, err_nxt;

  logic                  mem_we;
  logic [DEPTH_LG-1:0]   mem_addr;
  logic [OP_W-1:0]       mem_rdata;

  logic                  fetch_oor;
  logic                  ptr_oor;

  assign fetch_oor = (bus.ps_pm_add >> DEPTH_LG) != '0;
  assign ptr_oor   = (ptr >> DEPTH_LG) != '0;

  // Next-state, counter, error and RAM port selection.
  always_comb begin
    state_nxt = state;
    ptr_nxt   = ptr;
    cnt_nxt   = cnt;
    rd_ok_nxt = 1'b0;
    done_nxt  = 1'b0;
    err_nxt   = err_q;
    mem_we    = 1'b0;
    mem_addr  = bus.ps_pm_add[DEPTH_LG-1:0];

    case (state)
      ST_RUN: begin
        rd_ok_nxt = bus.ps_pm_cslt & ~bus.ps_pm_wrb & ~fetch_oor;
        if (bus.ps_pm_cslt & (bus.ps_pm_wrb | fetch_oor)) begin
          err_nxt = 1'b1;
        end
        if (bus.ld_start) begin
          ptr_nxt = bus.ld_base;
          cnt_nxt = bus.ld_len;
          if (bus.ld_len == '0) begin
            done_nxt = 1'b1;
          end else begin
            state_nxt = ST_LOAD;
          end
        end
      end

      ST_LOAD: begin
        mem_addr = ptr[DEPTH_LG-1:0];
        if (bus.ld_vld) begin
          // Out-of-range words are dropped but still consume the count.
          mem_we  = ~ptr_oor;
          err_nxt = err_q | ptr_oor;
          ptr_nxt = ptr + ADD_W'(1);
          cnt_nxt = cnt - ADD_W'(1);
          if (cnt == ADD_W'(1)) begin
            done_nxt  = 1'b1;
            state_nxt = ST_RUN;
          end
        end
      end

      default: state_nxt = ST_RUN;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= ST_RUN;
      ptr    <= '0;
      cnt    <= '0;
      rd_ok  <= 1'b0;
      done_q <= 1'b0;
      err_q  <= 1'b0;
    end else begin
      state  <= state_nxt;
      ptr    <= ptr_nxt;
      cnt    <= cnt_nxt;
      rd_ok  <= rd_ok_nxt;
      done_q <= done_nxt;
      err_q  <= err_nxt;
    end
  end

  pm_sram #(
    .AW (DEPTH_LG),
    .DW (OP_W)
  ) u_sram (
    .clk   (clk),
    .we    (mem_we),
    .addr  (mem_addr),
    .wdata (bus.ld_dt),
    .rdata (mem_rdata)
  );

  // RAM read data is qualified by the registered fetch-valid flag; anything else reads as NOP.
  assign bus.pm_ps_op = rd_ok ? mem_rdata : OP_W'(PM_NOP);
  assign bus.ld_rdy   = (state == ST_LOAD);
  assign bus.pm_busy  = (state == ST_LOAD);
  assign bus.ld_done  = done_q;
  assign bus.pm_err   = err_q;

endmodule

// File: tb/tb_pm_rspndr.sv
// Directed-plus-random bench for pm_rspndr against a word-level model of the PM array.
module tb_pm_rspndr;

  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  pm_rspndr_if bus ();

  pm_rspndr dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int checks   = 0;
  int failures = 0;

  logic [31:0] mm    [1024];
  bit          known [1024];
  bit          err_m;
  logic [15:0] kq    [$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(negedge clk);
  endtask

  task automatic idle();
    bus.ps_pm_cslt = 1'b0;
    bus.ps_pm_wrb  = 1'b0;
    bus.ps_pm_add  = '0;
    bus.ld_start   = 1'b0;
    bus.ld_base    = '0;
    bus.ld_len     = '0;
    bus.ld_vld     = 1'b0;
    bus.ld_dt      = '0;
  endtask

  task automatic do_reset();
    idle();
    rst = 1'b1;
    step();
    err_m = 1'b0;
    chk("rst_op",   bus.pm_ps_op, 32'h0);
    chk("rst_rdy",  bus.ld_rdy,   32'h0);
    chk("rst_busy", bus.pm_busy,  32'h0);
    chk("rst_done", bus.ld_done,  32'h0);
    chk("rst_err",  bus.pm_err,   32'h0);
    rst = 1'b0;
    step();
  endtask

  // One fetch; result is checked one cycle later, so back-to-back calls exercise pipelined fetches.
  task automatic fetch(input logic [15:0] add, input bit cslt, input bit wrb);
    logic [31:0] e;
    bit          cmp;
    bus.ps_pm_cslt = cslt;
    bus.ps_pm_wrb  = wrb;
    bus.ps_pm_add  = add;
    step();
    e   = 32'h0;
    cmp = 1'b1;
    if (cslt && (wrb || add >= 16'd1024)) begin
      err_m = 1'b1;
    end else if (cslt) begin
      if (known[add[9:0]]) e = mm[add[9:0]];
      else cmp = 1'b0;
    end
    if (cmp) chk("fetch_op", bus.pm_ps_op, e);
    chk("fetch_err", bus.pm_err, {31'b0, err_m});
    bus.ps_pm_cslt = 1'b0;
    bus.ps_pm_wrb  = 1'b0;
  endtask

  // Boot-load burst with random valid gaps and random fetches running alongside.
  task automatic load(input logic [15:0] base, input logic [15:0] len, input int gap, input bit poke);
    int          n;
    int          guard;
    logic [15:0] a;
    logic        v;
    logic [31:0] d;
    bus.ld_start = 1'b1;
    bus.ld_base  = base;
    bus.ld_len   = len;
    step();
    bus.ld_start = 1'b0;
    bus.ld_base  = 16'($urandom);
    bus.ld_len   = 16'($urandom);
    if (len == 16'd0) begin
      chk("zlen_done",     bus.ld_done, 32'h1);
      chk("zlen_busy",     bus.pm_busy, 32'h0);
      step();
      chk("zlen_done_clr", bus.ld_done, 32'h0);
      chk("zlen_busy2",    bus.pm_busy, 32'h0);
      return;
    end
    chk("ld_busy", bus.pm_busy, 32'h1);
    chk("ld_rdy",  bus.ld_rdy,  32'h1);
    n     = 0;
    guard = 0;
    while (n < int'(len) && guard < 4000) begin
      v = ($urandom_range(0, 99) >= gap);
      d = $urandom;
      bus.ld_vld     = v;
      bus.ld_dt      = d;
      bus.ps_pm_cslt = 1'($urandom_range(0, 1));
      bus.ps_pm_add  = 16'($urandom);
      bus.ld_start   = poke && (guard == 1);
      step();
      if (v) begin
        a = base + 16'(n);
        if (a < 16'd1024) begin
          mm[a[9:0]]    = d;
          known[a[9:0]] = 1'b1;
          kq.push_back(a);
        end else begin
          err_m = 1'b1;
        end
        n++;
      end
      chk("ld_fetch_nop", bus.pm_ps_op, 32'h0);
      chk("ld_err",       bus.pm_err,   {31'b0, err_m});
      if (n == int'(len)) begin
        chk("ld_done_end", bus.ld_done, 32'h1);
        chk("ld_rdy_end",  bus.ld_rdy,  32'h0);
        chk("ld_busy_end", bus.pm_busy, 32'h0);
      end else begin
        chk("ld_done_mid", bus.ld_done, 32'h0);
        chk("ld_rdy_mid",  bus.ld_rdy,  32'h1);
      end
      guard++;
    end
    bus.ld_vld     = 1'b0;
    bus.ld_start   = 1'b0;
    bus.ps_pm_cslt = 1'b0;
    chk("ld_count", 32'(n), 32'(len));
    step();
    chk("ld_done_clr", bus.ld_done, 32'h0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog expired checks=%0d failures=%0d", checks, failures);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [15:0] add;
    logic [31:0] w0, w1;
    rst = 1'b1;
    idle();
    step();

    // Reset values, deselected out-of-range fetch, illegal write request.
    do_reset();
    fetch(16'h0400, 1'b0, 1'b0);
    fetch(16'h0000, 1'b1, 1'b1);
    fetch(16'h0000, 1'b0, 1'b0);
    do_reset();

    // Four-word burst with valid held high, then back-to-back fetches.
    load(16'h0000, 16'd4, 0, 1'b0);
    for (int i = 0; i < 4; i++) fetch(16'(i), 1'b1, 1'b0);

    // Gapped burst overlapping the first one.
    load(16'h0003, 16'd3, 50, 1'b0);
    for (int i = 0; i < 6; i++) fetch(16'(i), 1'b1, 1'b0);

    // Out-of-range fetch makes the error sticky.
    fetch(16'h0400, 1'b1, 1'b0);
    fetch(16'h0001, 1'b1, 1'b0);
    fetch(16'h0002, 1'b0, 1'b0);

    // Zero-length burst and a burst with a stray ld_start inside it.
    load(16'h0010, 16'd0, 0, 1'b0);
    load(16'h0014, 16'd5, 30, 1'b1);
    fetch(16'h0014, 1'b1, 1'b0);
    fetch(16'h0018, 1'b1, 1'b0);

    // Bursts crossing the top of the array and wrapping the 16-bit pointer.
    do_reset();
    load(16'd1022, 16'd4, 20, 1'b0);
    load(16'hFFFF, 16'd2, 0, 1'b0);
    fetch(16'd1022, 1'b1, 1'b0);
    fetch(16'd1023, 1'b1, 1'b0);
    fetch(16'd0,    1'b1, 1'b0);

    // Random bursts and fetch traffic.
    for (int r = 0; r < 8; r++) begin
      load(16'($urandom_range(0, 1023)), 16'($urandom_range(1, 8)),
           $urandom_range(0, 60), 1'($urandom_range(0, 1)));
      for (int k = 0; k < 8; k++) begin
        if ($urandom_range(0, 9) == 0) add = 16'($urandom_range(1024, 65535));
        else add = kq[$urandom_range(0, kq.size() - 1)];
        fetch(add, 1'($urandom_range(0, 3) != 0), 1'b0);
      end
    end

    // Reset in the middle of a burst keeps the words already written.
    do_reset();
    w0 = $urandom;
    w1 = $urandom;
    bus.ld_start = 1'b1;
    bus.ld_base  = 16'd100;
    bus.ld_len   = 16'd5;
    step();
    bus.ld_start = 1'b0;
    bus.ld_vld   = 1'b1;
    bus.ld_dt    = w0;
    step();
    bus.ld_dt    = w1;
    step();
    mm[100] = w0; known[100] = 1'b1;
    mm[101] = w1; known[101] = 1'b1;
    bus.ld_vld = 1'b0;
    rst = 1'b1;
    step();
    err_m = 1'b0;
    chk("midrst_rdy",  bus.ld_rdy,   32'h0);
    chk("midrst_busy", bus.pm_busy,  32'h0);
    chk("midrst_op",   bus.pm_ps_op, 32'h0);
    chk("midrst_done", bus.ld_done,  32'h0);
    rst = 1'b0;
    step();
    chk("midrst_busy2", bus.pm_busy, 32'h0);
    fetch(16'd100, 1'b1, 1'b0);
    fetch(16'd101, 1'b1, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
